serial_adder: RTL

Parametrised bit-serial adder/subtractor for the ALU datapath. It computes a WIDTH-bit sum or difference one bit per clock, LSB first, through a single full-adder cell and a registered carry. Per-result fabric cost is constant, in exchange for WIDTH cycles of latency. It sits beside the combinational adder chain as the low-area arithmetic option and reports carry, signed overflow and zero flags with a start/done handshake.

---
 rtl/serial_adder.sv | 118 +++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell plus a registered carry,
// LSB first, WIDTH cycles per result with a start/ready/done handshake.

module serial_adder_fa (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

module serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] part;
    logic             cy;
    logic [CW-1:0]    cnt;

    logic             sbit;
    logic             co;
    logic [WIDTH-1:0] part_nxt;
    logic             last;

    serial_adder_fa u_fa (
        .x  (opa[0]),
        .y  (opb[0]),
        .ci (cy),
        .s  (sbit),
        .co (co)
    );

    // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
    assign part_nxt = {sbit, part[WIDTH-1:1]};
    assign last     = (state == RUN) && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ready    <= 1'b1;
            done     <= 1'b0;
            opa      <= '0;
            opb      <= '0;
            part     <= '0;
            cy       <= 1'b0;
            cnt      <= '0;
            sum      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        ready <= 1'b0;
                        opa   <= a;
                        opb   <= sub ? ~b : b;
                        cy    <= sub;
                        cnt   <= '0;
                        part  <= '0;
                    end
                end
                RUN: begin
                    part <= part_nxt;
                    opa  <= opa >> 1;
                    opb  <= opb >> 1;
                    cy   <= co;
                    cnt  <= cnt + CW'(1);
                    if (last) begin
                        // cy still holds the carry into the MSB cell here.
                        state    <= DONE;
                        done     <= 1'b1;
                        sum      <= part_nxt;
                        carry    <= co;
                        overflow <= cy ^ co;
                        zero     <= (part_nxt == '0);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    ready <= 1'b1;
                end
            endcase
        end
    end
endmodule
